pwm_encoder_mc: RTL and testbench
=================================

PWM_ENCODER_MC -- requirements
Module: pwm_encoder_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of PWM channels.
REQ-002 SHALL have parameter VAL_W, default 12, command value width in bits.
REQ-003 SHALL have parameter CLK_DIV, default 50, clk cycles per 1 us tick (>=1).
REQ-004 SHALL have parameter FRAME_US, default 20000, frame period in ticks.
REQ-005 SHALL have parameter MIN_US, default 1000, minimum pulse width in ticks.
REQ-006 SHALL have parameter MAX_US, default 2000, maximum pulse width in ticks (MIN_US <= MAX_US < FRAME_US).
REQ-007 SHALL have parameter TIMEOUT_FRAMES, default 10, frames without update before failsafe (>=1).
REQ-008 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-009 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-010 SHALL have port val  input  VAL_W x NUM_CH (unpacked array)  per-channel pulse command, offset above MIN_US.
REQ-011 SHALL have port val_valid  input  1  one-cycle strobe capturing all val entries.
REQ-012 SHALL have port arm  input  1  request to enable outputs.
REQ-013 SHALL have port pwm  output  NUM_CH  registered PWM outputs.
REQ-014 SHALL have port frame_start  output  1  one-cycle pulse at each frame boundary.
REQ-015 SHALL have port failsafe  output  1  high while command timeout active.

Function
REQ-016 SHALL generate a tick every CLK_DIV clk cycles via prescaler counting 0..CLK_DIV-1.
REQ-017 SHALL advance a frame counter us_cnt 0..FRAME_US-1 on each tick, wrapping to 0; width $clog2(FRAME_US).
REQ-018 SHALL, on the tick where us_cnt wraps to 0, assert frame_start for exactly one clk cycle.
REQ-019 SHALL, on val_valid, copy val into a pending buffer and set a pending flag; a later val_valid in the same frame overwrites the buffer.
REQ-020 SHALL load active widths from the pending buffer only at a frame boundary, then clear pending; val changes never alter the frame in progress.
REQ-021 SHALL compute width_i = min(MIN_US + val_i, MAX_US) using arithmetic wide enough to avoid overflow.
REQ-022 SHALL sample arm only at frame boundaries into armed; arm changes mid-frame take effect at the next frame.
REQ-023 SHALL drive pwm[i] = armed AND (us_cnt < width_i), registered, so pwm rises in the same cycle frame_start is high.
REQ-024 SHALL, when armed is low, hold pwm at all zeros for the whole frame.
REQ-025 SHALL count consecutive frames with no val_valid; at TIMEOUT_FRAMES, set failsafe at that boundary.
REQ-026 SHALL, while failsafe, use width MIN_US on every channel regardless of active widths.
REQ-027 SHALL clear failsafe and the timeout count at the first frame boundary with pending set; new widths apply that same frame.
REQ-028 SHALL, when val_valid coincides with the boundary cycle, treat the data as pending for the following frame.

Reset
REQ-029 SHALL, while rst_n is low at a clk edge, set pwm=0, frame_start=0, failsafe=1, armed=0, pending=0, prescaler=0, us_cnt=0, timeout count=0, all active widths=MIN_US.
REQ-030 SHALL, on reset assertion mid-pulse, drive pwm low on the next clk edge.
REQ-031 SHALL emit the first frame_start on the first tick after reset release and count frames from there.

Verification (CLK_DIV=1, FRAME_US=100, MIN_US=10, MAX_US=20, TIMEOUT_FRAMES=3)
REQ-032 SHALL cover: reset release, arm=1, val=5 all channels with val_valid -> next frame each pwm high 15 cycles of 100, failsafe clears.
REQ-033 SHALL cover: val[2]=50 -> channel 2 high 20 cycles (clamped); others unchanged.
REQ-034 SHALL cover: val changed 8 to 2 at us_cnt=5 -> current frame 18 cycles, next frame 12.
REQ-035 SHALL cover: val_valid stopped after frame N -> at frame N+3 boundary failsafe=1 and all pwm high 10 cycles; one val_valid restores commanded widths next frame.
REQ-036 SHALL cover: arm dropped at us_cnt=3 with width 15 -> current pulse completes at 15, next frame pwm stays 0.
REQ-037 SHALL cover: rst_n low at us_cnt=7 -> pwm=0 next cycle, failsafe=1, widths back to MIN_US.

Source files
------------

// File: rtl/pwm_encoder_mc.sv
// rtl/pwm_encoder_mc.sv - multi-channel servo-style PWM frame encoder
// Commands are double-buffered and only take effect at frame boundaries.
module pwm_encoder_mc #(
  parameter int NUM_CH         = 4,
  parameter int VAL_W          = 12,
  parameter int CLK_DIV        = 50,
  parameter int FRAME_US       = 20000,
  parameter int MIN_US         = 1000,
  parameter int MAX_US         = 2000,
  parameter int TIMEOUT_FRAMES = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [VAL_W-1:0]  val [NUM_CH],
  input  logic              val_valid,
  input  logic              arm,
  output logic [NUM_CH-1:0] pwm,
  output logic              frame_start,
  output logic              failsafe
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int UW = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
  localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
  localparam int SW = ((VAL_W > UW) ? VAL_W : UW) + 1;

  logic [DW-1:0]     div_cnt;
  logic [UW-1:0]     us_cnt;
  logic [UW-1:0]     us_next;
  logic [TW-1:0]     to_cnt;
  logic [TW-1:0]     to_next;
  logic              started;
  logic              armed;
  logic              armed_next;
  logic              pending;
  logic              failsafe_next;
  logic              tick;
  logic              boundary;
  logic [VAL_W-1:0]  pend_val   [NUM_CH];
  logic [UW-1:0]     width      [NUM_CH];
  logic [UW-1:0]     width_next [NUM_CH];
  logic [UW-1:0]     cmd_width  [NUM_CH];
  logic [NUM_CH-1:0] pwm_next;

  assign tick = (div_cnt == DW'(CLK_DIV - 1));
  // The first tick after reset opens frame 0 instead of advancing the count.
  assign boundary = tick && (!started || us_cnt == UW'(FRAME_US - 1));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_clamp
    logic [SW-1:0] sum;
    assign sum          = SW'(MIN_US) + SW'(pend_val[g]);
    assign cmd_width[g] = (sum > SW'(MAX_US)) ? UW'(MAX_US) : sum[UW-1:0];
  end

  always_comb begin
    us_next       = us_cnt;
    armed_next    = armed;
    failsafe_next = failsafe;
    to_next       = to_cnt;
    width_next    = width;
    pwm_next      = '0;
    if (boundary) begin
      us_next    = '0;
      armed_next = arm;
      if (pending) begin
        to_next       = '0;
        failsafe_next = 1'b0;
        width_next    = cmd_width;
      end else begin
        if (to_cnt != TW'(TIMEOUT_FRAMES)) to_next = to_cnt + 1'b1;
        if (to_next == TW'(TIMEOUT_FRAMES)) failsafe_next = 1'b1;
      end
    end else if (tick) begin
      us_next = us_cnt + 1'b1;
    end
    // pwm is computed from next-state values so it rises together with frame_start.
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_next[i] = armed_next &&
                    (us_next < (failsafe_next ? UW'(MIN_US) : width_next[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      us_cnt      <= '0;
      to_cnt      <= '0;
      started     <= 1'b0;
      armed       <= 1'b0;
      pending     <= 1'b0;
      failsafe    <= 1'b1;
      frame_start <= 1'b0;
      pwm         <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        width[i]    <= UW'(MIN_US);
        pend_val[i] <= '0;
      end
    end else begin
      div_cnt     <= tick ? '0 : div_cnt + 1'b1;
      us_cnt      <= us_next;
      to_cnt      <= to_next;
      started     <= started | tick;
      armed       <= armed_next;
      failsafe    <= failsafe_next;
      frame_start <= boundary;
      pwm         <= pwm_next;
      width       <= width_next;
      // A strobe on the boundary cycle lands in the buffer for the following frame.
      if (val_valid) begin
        pending  <= 1'b1;
        pend_val <= val;
      end else if (boundary) begin
        pending <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pwm_encoder_mc.sv
// tb/tb_pwm_encoder_mc.sv - scoreboard bench for pwm_encoder_mc
// Driver queues per-frame expected widths; monitor measures each frame between frame_start pulses.
module tb_pwm_encoder_mc;
  localparam int NCH   = 4;
  localparam int VW    = 12;
  localparam int FRAME = 100;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           val_valid = 1'b0;
  logic           arm = 1'b0;
  logic [VW-1:0]  val [NCH];
  logic [NCH-1:0] pwm;
  logic           frame_start;
  logic           failsafe;

  typedef struct packed {
    logic           fs;
    logic [3:0][7:0] w;
  } exp_t;

  exp_t q [$];
  int   total  = 0;
  int   bad    = 0;
  int   waited = 0;

  pwm_encoder_mc #(
    .NUM_CH(NCH), .VAL_W(VW), .CLK_DIV(1), .FRAME_US(FRAME),
    .MIN_US(10), .MAX_US(20), .TIMEOUT_FRAMES(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .val(val),
    .val_valid(val_valid),
    .arm(arm),
    .pwm(pwm),
    .frame_start(frame_start),
    .failsafe(failsafe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic wait_frame();
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
      if (waited > 3 * FRAME) begin
        total++;
        bad++;
        $display("FAIL frame_start timeout: waited %0d cycles, required <= %0d", waited, 3 * FRAME);
        finish_run();
      end
    end while (!frame_start);
  endtask

  task automatic next_frame(input int w0, input int w1, input int w2, input int w3, input logic fs);
    exp_t e;
    wait_frame();
    e.fs   = fs;
    e.w[0] = 8'(w0);
    e.w[1] = 8'(w1);
    e.w[2] = 8'(w2);
    e.w[3] = 8'(w3);
    q.push_back(e);
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_val(input int v0, input int v1, input int v2, input int v3);
    val[0] = VW'(v0);
    val[1] = VW'(v1);
    val[2] = VW'(v2);
    val[3] = VW'(v3);
  endtask

  task automatic send(input int v0, input int v1, input int v2, input int v3);
    set_val(v0, v1, v2, v3);
    val_valid = 1'b1;
    @(negedge clk);
    val_valid = 1'b0;
  endtask

  initial begin
    bit   active;
    int   n;
    int   cnt [NCH];
    logic fs0;
    exp_t e;
    active = 1'b0;
    n      = 0;
    fs0    = 1'b0;
    for (int c = 0; c < NCH; c++) cnt[c] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
        continue;
      end
      if (frame_start) begin
        if (active) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected frame: queue empty after %0d samples, required a queued frame", n);
          end else begin
            e = q.pop_front();
            check("frame length", n, FRAME);
            check("failsafe", int'(fs0), int'(e.fs));
            for (int c = 0; c < NCH; c++)
              check($sformatf("pwm[%0d] width", c), cnt[c], int'(e.w[c]));
          end
        end
        active = 1'b1;
        n      = 0;
        fs0    = failsafe;
        for (int c = 0; c < NCH; c++) cnt[c] = 0;
      end
      if (active) begin
        n++;
        for (int c = 0; c < NCH; c++) cnt[c] += int'(pwm[c]);
      end
    end
  end

  initial begin
    set_val(0, 0, 0, 0);
    skip(3);
    check("reset pwm", int'(pwm), 0);
    check("reset failsafe", int'(failsafe), 1);
    check("reset frame_start", int'(frame_start), 0);

    arm   = 1'b1;
    rst_n = 1'b1;
    next_frame(10, 10, 10, 10, 1'b1);
    check("first frame_start latency", waited, 1);
    skip(10);
    send(5, 5, 5, 5);
    next_frame(15, 15, 15, 15, 1'b0);
    skip(10);
    send(5, 5, 50, 5);
    next_frame(15, 15, 20, 15, 1'b0);
    skip(10);
    send(8, 8, 8, 8);
    next_frame(18, 18, 18, 18, 1'b0);
    skip(5);
    send(2, 2, 2, 2);
    next_frame(12, 12, 12, 12, 1'b0);
    next_frame(12, 12, 12, 12, 1'b0);
    next_frame(12, 12, 12, 12, 1'b0);
    next_frame(10, 10, 10, 10, 1'b1);
    skip(20);
    send(1, 2, 3, 4);
    next_frame(11, 12, 13, 14, 1'b0);

    // Strobe on the boundary cycle: must wait one more frame.
    skip(99);
    set_val(5, 5, 5, 5);
    val_valid = 1'b1;
    next_frame(11, 12, 13, 14, 1'b0);
    val_valid = 1'b0;
    next_frame(15, 15, 15, 15, 1'b0);
    skip(3);
    arm = 1'b0;
    next_frame(0, 0, 0, 0, 1'b0);
    skip(30);
    arm = 1'b1;

    // Frame cut short by reset, so nothing is queued for it.
    wait_frame();
    skip(7);
    check("pulse high before reset", int'(pwm), 15);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid-pulse reset pwm", int'(pwm), 0);
    check("mid-pulse reset failsafe", int'(failsafe), 1);
    check("mid-pulse reset frame_start", int'(frame_start), 0);
    skip(2);
    rst_n = 1'b1;
    next_frame(10, 10, 10, 10, 1'b1);
    check("restart frame_start latency", waited, 1);
    wait_frame();
    skip(2);
    check("scoreboard drained", q.size(), 0);
    finish_run();
  end
endmodule
